// File: rtl/fifo_queue.sv
// rtl/fifo_queue.sv - synchronous FIFO queue with registered output, full/empty flags and overflow/underflow pulses
// Optional occupancy port `level` is present when FIFO_LEVEL_EN is defined.
module fifo_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wn,
  input  logic             rn,
  input  logic [WIDTH-1:0] DATAIN,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf
`ifdef FIFO_LEVEL_EN
  ,
  output logic [AW:0]      level
`endif
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic [AW:0]      cnt_next;
  logic             push;
  logic             pop;

  // A write at full is still accepted when a read frees the head slot in the same edge.
  always_comb begin
    push     = wn && (!full || rn);
    pop      = rn && !empty;
    cnt_next = cnt;
    if (push && !pop) cnt_next = cnt + 1'b1;
    else if (pop && !push) cnt_next = cnt - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      DATAOUT <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp      <= rp + 1'b1;
        DATAOUT <= mem[rp];
      end
      cnt   <= cnt_next;
      full  <= (cnt_next == (AW+1)'(DEPTH));
      empty <= (cnt_next == '0);
      ovf   <= wn && full && !rn;
      udf   <= rn && empty;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clock) begin
    if (reset && push) mem[wp] <= DATAIN;
  end

`ifdef FIFO_LEVEL_EN
  assign level = cnt;
`endif

endmodule

// File: tb/tb_fifo_queue.sv
// tb/tb_fifo_queue.sv - randomized and directed self-checking bench for fifo_queue against a queue model
module tb_fifo_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             wn    = 1'b0;
  logic             rn    = 1'b0;
  logic [WIDTH-1:0] DATAIN = '0;
  logic [WIDTH-1:0] DATAOUT;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             udf;
`ifdef FIFO_LEVEL_EN
  logic [AW:0]      level;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_ovf  = 1'b0;
  logic             m_udf  = 1'b0;

  fifo_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clock  (clock),
    .reset  (reset),
    .wn     (wn),
    .rn     (rn),
    .DATAIN (DATAIN),
    .DATAOUT(DATAOUT),
    .full   (full),
    .empty  (empty),
    .ovf    (ovf),
    .udf    (udf)
`ifdef FIFO_LEVEL_EN
    ,
    .level  (level)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock edge: drive inputs, advance the model by the rules, then compare all outputs.
  task automatic step(input logic rst_n, input logic w, input logic r, input logic [WIDTH-1:0] d);
    bit was_full, was_empty;
    reset  = rst_n;
    wn     = w;
    rn     = r;
    DATAIN = d;
    @(posedge clock);
    #1;
    if (!rst_n) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_ovf = w && was_full && !r;
      m_udf = r && was_empty;
      if (r && !was_empty) m_dout = q.pop_front();
      if (w && (!was_full || r)) q.push_back(d);
    end
    check("dataout", 32'(DATAOUT), 32'(m_dout));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("udf", 32'(udf), 32'(m_udf));
`ifdef FIFO_LEVEL_EN
    check("level", 32'(level), 32'(q.size()));
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] order_vals [7];
    int pw;
    int pr;
    order_vals = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15};

    // Reset overrides simultaneous strobes
    step(1'b0, 1'b1, 1'b1, 8'd33);
    check("reset_dataout", 32'(DATAOUT), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);

    // Order preservation and underflow after draining
    foreach (order_vals[i]) step(1'b1, 1'b1, 1'b0, order_vals[i]);
    foreach (order_vals[i]) begin
      step(1'b1, 1'b0, 1'b1, 8'd0);
      check("order_out", 32'(DATAOUT), 32'(order_vals[i]));
    end
    step(1'b1, 1'b0, 1'b1, 8'd0);
    check("underflow_udf", 32'(udf), 32'd1);
    check("underflow_hold", 32'(DATAOUT), 32'd15);

    // Fill, overflow, simultaneous at full, drain
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b1, 1'b0, 8'(i));
    check("full_flag", 32'(full), 32'd1);
    step(1'b1, 1'b1, 1'b0, 8'd99);
    check("overflow_ovf", 32'(ovf), 32'd1);
    step(1'b1, 1'b1, 1'b1, 8'd77);
    check("simul_full_out", 32'(DATAOUT), 32'd1);
    check("simul_full_flag", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, 8'd0);
    check("last_out_77", 32'(DATAOUT), 32'd77);

    // Simultaneous at empty: write accepted, read rejected
    step(1'b1, 1'b1, 1'b1, 8'd5);
    check("simul_empty_udf", 32'(udf), 32'd1);
    check("simul_empty_hold", 32'(DATAOUT), 32'd77);
    step(1'b1, 1'b0, 1'b1, 8'd0);
    check("simul_empty_pop", 32'(DATAOUT), 32'd5);

    // Pointer wrap over several rounds
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 8'(round * 16 + i + 1));
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 8'd0);
      check("wrap_empty", 32'(empty), 32'd1);
    end

    // Mid-operation reset discards queued data
    step(1'b1, 1'b1, 1'b0, 8'd10);
    step(1'b1, 1'b1, 1'b0, 8'd20);
    step(1'b1, 1'b1, 1'b0, 8'd30);
    step(1'b1, 1'b0, 1'b1, 8'd0);
    check("midreset_pop", 32'(DATAOUT), 32'd10);
    step(1'b0, 1'b0, 1'b0, 8'd0);
    check("midreset_empty", 32'(empty), 32'd1);
    step(1'b1, 1'b1, 1'b0, 8'd44);
    step(1'b1, 1'b0, 1'b1, 8'd0);
    check("midreset_after", 32'(DATAOUT), 32'd44);

    // Random traffic with phases biased toward filling and draining
    for (int ph = 0; ph < 8; ph++) begin
      pw = (ph % 2 == 0) ? 75 : 30;
      pr = (ph % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 60; i++) begin
        step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
             $urandom_range(0, 99) < pw,
             $urandom_range(0, 99) < pr,
             8'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_queue.md
# fifo_queue

Synchronous first-in-first-out queue; companion to the `jLIFO` stack, sharing its port set and write/read strobes but draining from the opposite end, so the oldest word leaves first. Used wherever producer order must be preserved: sample buffering, command queues, test-bench stimulus replay. One clock domain, registered output, full/empty status, one-cycle overflow/underflow pulses.

## Interface
- `WIDTH`, 8, data word width in bits
- `DEPTH`, 8, number of entries; power of two, ≥ 2
- `AW`, 3, pointer width, log2(DEPTH)

- `clock`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-low reset, sampled on rising edge of `clock`
- `wn`  input  1  write strobe; push `DATAIN` at the edge it is sampled high
- `rn`  input  1  read strobe; pop head into `DATAOUT` at the edge it is sampled high
- `DATAIN`  input  WIDTH  write data
- `DATAOUT`  output  WIDTH  registered read data; holds last popped word
- `full`  output  1  registered; high when DEPTH entries stored
- `empty`  output  1  registered; high when 0 entries stored
- `ovf`  output  1  one-cycle pulse: write rejected because full
- `udf`  output  1  one-cycle pulse: read rejected because empty
- `level`  output  AW+1  occupancy, 0..DEPTH (only with `FIFO_LEVEL_EN`)

## Operation
- Storage: DEPTH × WIDTH register array, write pointer `wp`, read pointer `rp` (AW bits each), occupancy `cnt` (AW+1 bits).
- Push (`wn`=1, accepted): `mem[wp] <= DATAIN`; `wp <= wp+1` mod DEPTH; `cnt+1`.
- Pop (`rn`=1, accepted): `DATAOUT <= mem[rp]`; `rp <= rp+1` mod DEPTH; `cnt-1`.
- Pointer wrap DEPTH-1 → 0 is natural AW-bit roll-over; no extra logic.
- `full` = (`cnt_next` == DEPTH), `empty` = (`cnt_next` == 0), both registered.
- Acceptance per edge, by state before the edge:
  - `wn` only, not full: push. Full: ignored, `ovf`=1 next cycle.
  - `rn` only, not empty: pop. Empty: ignored, `DATAOUT` holds, `udf`=1 next cycle.
  - `wn` & `rn`, empty: push only; read rejected, `udf`=1, `DATAOUT` holds (no write-through).
  - `wn` & `rn`, full: both accepted; pop returns the old head, `cnt` unchanged, `full` stays 1, no `ovf`.
  - `wn` & `rn`, otherwise: both accepted, `cnt` unchanged.
- `ovf`, `udf` are 0 on every cycle without a rejection.
- Storage array is not cleared by reset; contents unobservable until rewritten.

## Timing
- Reset (`reset`=0 at an edge): `DATAOUT`=0, `full`=0, `empty`=1, `ovf`=0, `udf`=0, `level`=0, `wp`=`rp`=0. Overrides any `wn`/`rn` in the same cycle; mid-operation reset discards all queued data.
- Read latency 1: `rn` sampled high at edge k → popped word on `DATAOUT` immediately after edge k; no extra dummy cycle.
- Write-to-read latency 1: word pushed at edge k is poppable at edge k+1.
- Flags update at the same edge as the push/pop that changes occupancy.
- `DATAOUT` changes only on an accepted pop or reset.

## Configuration
- `FIFO_LEVEL_EN` defined: `level` port present, driven by registered `cnt` (0..DEPTH), updates with flags.
- Not defined: `level` port absent; `cnt` internal only; all other behaviour identical.

## Test plan
- Reset: hold `reset`=0 one edge with `wn`=`rn`=1 → `empty`=1, `full`=0, `DATAOUT`=0, `ovf`=`udf`=0, `level`=0.
- Order: push 100,150,200,40,70,65,15, then 7 pops → `DATAOUT` 100,150,200,40,70,65,15 after successive edges; `empty`=1 after 7th pop; 8th pop → `udf`=1, `DATAOUT` stays 15.
- Full: push 1..8 → `full`=1, `level`=8; push 99 → `ovf`=1, ignored; 8 pops return 1..8, 99 never appears.
- Simultaneous: at full, `wn`=`rn`=1 with `DATAIN`=77 → `DATAOUT`=1, `full` stays 1, 77 last out. At empty, `wn`=`rn`=1 with `DATAIN`=5 → `udf`=1, `DATAOUT` unchanged, `level`=1, next pop gives 5.
- Wrap: 3 rounds of push 6 / pop 6 (pointers cross DEPTH-1 → 0) → each round order preserved, `empty`=1 between rounds.
- Mid-op reset: push 10,20,30, pop once (10), assert reset → `empty`=1, `DATAOUT`=0; push 44, pop → 44.
